packed_lane_serializer: RTL

Sequencer that accepts a packed two-dimensional vector of N lanes × W bits and emits it one lane per beat over a valid/ready stream. Lane order is chosen per vector: MSB-lane-first (index N-1 down to 0) or LSB-lane-first (index 0 up to N-1). It sits between a parameter/config producer that supplies whole packed arrays, such as a packed constant of shape [N-1:0][W-1:0], and a narrow W-bit consumer. It owns the lane-index counter and all msb/lsb bound handling.

---
 rtl/packed_lane_serializer.sv | 84 ++++++++
 1 files changed

// File: rtl/packed_lane_serializer.sv
`default_nettype none
// ============================================================================
// Module      : packed_lane_serializer
// Description : Emits a captured N x W packed vector one lane per beat over a
//               valid/ready stream, MSB-lane-first or LSB-lane-first.
// Revision    : 1.0 - initial release
// ============================================================================
module packed_lane_serializer #(
    parameter int N = 3,
    parameter int W = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load_valid,
    output logic                o_load_ready,
    input  logic [N-1:0][W-1:0] i_load_data,
    input  logic                i_msb_first,
    input  logic                i_abort,
    output logic                o_lane_valid,
    input  logic                i_lane_ready,
    output logic [W-1:0]        o_lane_data,
    output logic [IW-1:0]       o_lane_index,
    output logic                o_lane_last,
    output logic                o_busy
);

    localparam logic [0:0]    c_st_idle  = 1'b0;
    localparam logic [0:0]    c_st_send  = 1'b1;
    localparam logic [IW-1:0] c_last_idx = IW'(N - 1);
    localparam logic [IW-1:0] c_one      = IW'(1);

    logic [0:0]          r_state;
    logic [N-1:0][W-1:0] r_data;
    logic                r_dir;
    logic [IW-1:0]       r_idx;

    logic w_send;
    logic w_last;
    logic w_load_fire;

    assign w_send = (r_state == c_st_send);
    // Final lane depends on direction: index 0 when descending, N-1 when ascending.
    assign w_last = r_dir ? (r_idx == '0) : (r_idx == c_last_idx);

    assign o_load_ready = i_rst & ~i_abort &
                          (~w_send | (i_lane_ready & w_last));
    assign w_load_fire  = i_load_valid & o_load_ready;

    assign o_lane_valid = w_send;
    assign o_busy       = w_send;
    assign o_lane_data  = w_send ? r_data[r_idx] : '0;
    assign o_lane_index = w_send ? r_idx : '0;
    assign o_lane_last  = w_send & w_last;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= c_st_idle;
            r_data  <= '0;
            r_dir   <= 1'b0;
            r_idx   <= '0;
        end else if (w_load_fire) begin
            // Covers both a load from IDLE and a back-to-back load on the last beat.
            r_state <= c_st_send;
            r_data  <= i_load_data;
            r_dir   <= i_msb_first;
            r_idx   <= i_msb_first ? c_last_idx : '0;
        end else if (w_send) begin
            if (i_abort) begin
                r_state <= c_st_idle;
            end else if (i_lane_ready) begin
                if (w_last) begin
                    r_state <= c_st_idle;
                end else if (r_dir) begin
                    r_idx <= r_idx - c_one;
                end else begin
                    r_idx <= r_idx + c_one;
                end
            end
        end
    end

endmodule
`default_nettype wire
